// File: rtl/wb_dma_pkg.sv
// Shared definitions for the Wishbone block-copy engine: register map,
// CTRL bit positions and transfer state encoding.
package wb_dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_DONE   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_ABORT  = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    GAP1,
    WR,
    GAP2
  } state_t;

endpackage

// File: rtl/wb_dma_regs.sv
// Configuration slave: address decode, registered ack, SRC/DST/LEN/CTRL
// storage and single-cycle START/ABORT pulses toward the transfer engine.
module wb_dma_regs
  import wb_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        busy,
  input  logic        done_set,
  output logic [31:0] src,
  output logic [31:0] dst,
  output logic [15:0] len,
  output logic        irq_en,
  output logic        done,
  output logic        start,
  output logic        abort
);

  logic        access;
  logic        wr;
  logic [1:0]  idx;
  logic [31:0] rdata;
  logic        unused_bits;

  assign access      = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr          = access & wb_we_i;
  assign idx         = wb_adr_i[3:2];
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0]};

  always_comb begin
    rdata = '0;
    case (idx)
      REG_SRC:  rdata = src;
      REG_DST:  rdata = dst;
      REG_LEN:  rdata = {16'h0000, len};
      REG_CTRL: begin
        rdata[CTRL_START]  = busy;
        rdata[CTRL_DONE]   = done;
        rdata[CTRL_IRQ_EN] = irq_en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      src      <= '0;
      dst      <= '0;
      len      <= '0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      start    <= 1'b0;
      abort    <= 1'b0;
    end else begin
      wb_ack_o <= access;
      start    <= 1'b0;
      abort    <= 1'b0;
      if (access && !wb_we_i)
        wb_dat_o <= rdata;
      // Address/length writes during a transfer are acknowledged but dropped.
      if (wr) begin
        case (idx)
          REG_SRC:  if (!busy) src <= {wb_dat_i[31:2], 2'b00};
          REG_DST:  if (!busy) dst <= {wb_dat_i[31:2], 2'b00};
          REG_LEN:  if (!busy) len <= wb_dat_i[15:0];
          REG_CTRL: begin
            irq_en <= wb_dat_i[CTRL_IRQ_EN];
            start  <= wb_dat_i[CTRL_START] & ~busy;
            abort  <= wb_dat_i[CTRL_ABORT] & busy;
          end
          default: ;
        endcase
      end
      if (done_set)
        done <= 1'b1;
      else if (wr && idx == REG_CTRL && wb_dat_i[CTRL_DONE])
        done <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_dma.sv
// Wishbone block-copy engine top: config slave plus a master FSM that reads
// one word, releases the bus for a cycle, writes it, and releases again.
module wb_dma
  import wb_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  output logic        intr
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic        irq_en;
  logic        done;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done_set;
  logic        abort_pend;
  logic [31:0] src_cnt;
  logic [31:0] dst_cnt;
  logic [15:0] remaining;
  logic [31:0] data;

  assign busy = (state != IDLE);

  wb_dma_regs u_regs (
    .clk      (clk),
    .rst      (rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .busy     (busy),
    .done_set (done_set),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .irq_en   (irq_en),
    .done     (done),
    .start    (start),
    .abort    (abort)
  );

  always_comb begin
    state_nx = state;
    done_set = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == 16'd0) done_set = 1'b1;
          else              state_nx = RD;
        end
      end
      RD:   if (m_ack_i) state_nx = GAP1;
      GAP1: state_nx = WR;
      WR:   if (m_ack_i) state_nx = GAP2;
      GAP2: begin
        if (remaining != 16'd0 && !abort_pend && !abort) begin
          state_nx = RD;
        end else begin
          state_nx = IDLE;
          done_set = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      src_cnt    <= '0;
      dst_cnt    <= '0;
      remaining  <= '0;
      data       <= '0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start && len != 16'd0) begin
            src_cnt   <= src;
            dst_cnt   <= dst;
            remaining <= len;
          end
        end
        RD: if (m_ack_i) data <= m_dat_i;
        WR: begin
          if (m_ack_i) begin
            src_cnt   <= src_cnt + 32'd4;
            dst_cnt   <= dst_cnt + 32'd4;
            remaining <= remaining - 16'd1;
          end
        end
        default: ;
      endcase
      // Abort is honoured at the next gap so the bus cycle in flight finishes.
      if (state_nx == IDLE) abort_pend <= 1'b0;
      else if (abort)       abort_pend <= 1'b1;
    end
  end

  assign m_cyc_o = (state == RD) || (state == WR);
  assign m_stb_o = m_cyc_o;
  assign m_we_o  = (state == WR);
  assign m_sel_o = m_cyc_o ? 4'hF : 4'h0;
  assign m_adr_o = (state == RD) ? src_cnt : ((state == WR) ? dst_cnt : 32'h0);
  assign m_dat_o = m_we_o ? data : 32'h0;
  assign intr    = done & irq_en;

endmodule
